uc_secuenciada: RTL and testbench

UC_SECUENCIADA -- requirements
Module: uc_secuenciada

---
 rtl/uc_pkg.sv | 23 ++
 rtl/uc_decod.sv | 46 ++++
 rtl/uc_secuenciada.sv | 91 +++++++++
 tb/tb_uc_secuenciada.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
// rtl/uc_pkg.sv - shared opcode fields, FSM states and ALU codes for the sequencer
package uc_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_STEP   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  // opcode[5:2] groups when opcode[5]=0
  localparam logic [3:0] OP_LI   = 4'b0000;
  localparam logic [3:0] OP_FLOW = 4'b0001;

  // opcode[1:0] inside the flow group
  localparam logic [1:0] FL_J    = 2'b00;
  localparam logic [1:0] FL_JZ   = 2'b01;
  localparam logic [1:0] FL_JNZ  = 2'b10;
  localparam logic [1:0] FL_HALT = 2'b11;

  localparam logic [2:0] ALU_PASS_B = 3'b000;

endpackage

// File: rtl/uc_decod.sv
// rtl/uc_decod.sv - combinational instruction decode from opcode and zero flag
module uc_decod
  import uc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       s_inc,
  output logic       s_inm,
  output logic       we3,
  output logic       wez,
  output logic [2:0] alu_op,
  output logic       pc_en,
  output logic       is_halt
);

  always_comb begin
    s_inc   = 1'b1;
    s_inm   = 1'b0;
    we3     = 1'b0;
    wez     = 1'b0;
    alu_op  = ALU_PASS_B;
    is_halt = 1'b0;
    if (opcode[5]) begin
      alu_op = opcode[4:2];
      we3    = 1'b1;
      wez    = 1'b1;
    end else if (opcode[4]) begin
      // NOP group: defaults already describe it
      s_inc = 1'b1;
    end else if (opcode[5:2] == OP_LI) begin
      s_inm = 1'b1;
      we3   = 1'b1;
    end else if (opcode[5:2] == OP_FLOW) begin
      case (opcode[1:0])
        FL_J:    s_inc = 1'b0;
        FL_JZ:   s_inc = ~zero;
        FL_JNZ:  s_inc = zero;
        default: is_halt = 1'b1;
      endcase
    end
  end

  // HALT keeps the PC where it is
  assign pc_en = ~is_halt;

endmodule

// File: rtl/uc_secuenciada.sv
// rtl/uc_secuenciada.sv - run/step/halt sequencer with gated enables and instruction counter
module uc_secuenciada
  import uc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        run,
  input  logic        step,
  output logic        s_inc,
  output logic        s_inm,
  output logic        we3,
  output logic        wez,
  output logic [2:0]  ALUOp,
  output logic        pc_en,
  output logic        halted,
  output logic [15:0] instr_count
);

  state_t state;
  logic   step_q;
  logic   exec;
  logic   dec_we3;
  logic   dec_wez;
  logic   dec_pc_en;
  logic   dec_halt;

  uc_decod u_decod (
    .opcode  (opcode),
    .zero    (zero),
    .s_inc   (s_inc),
    .s_inm   (s_inm),
    .we3     (dec_we3),
    .wez     (dec_wez),
    .alu_op  (ALUOp),
    .pc_en   (dec_pc_en),
    .is_halt (dec_halt)
  );

  assign exec  = ((state == S_RUN) || (state == S_STEP)) && !dec_halt;
  assign pc_en = dec_pc_en & exec;
  assign we3   = dec_we3 & exec;
  assign wez   = dec_wez & exec;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      step_q <= 1'b0;
      halted <= 1'b0;
    end else begin
      step_q <= step;
      case (state)
        S_IDLE: begin
          if (run)
            state <= S_RUN;
          else if (step && !step_q)
            state <= S_STEP;
        end
        S_RUN: begin
          if (dec_halt) begin
            state  <= S_HALTED;
            halted <= 1'b1;
          end else if (!run) begin
            state <= S_IDLE;
          end
        end
        S_STEP: begin
          if (dec_halt) begin
            state  <= S_HALTED;
            halted <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          state  <= S_HALTED;
          halted <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      instr_count <= 16'h0000;
    else if (exec && (instr_count != 16'hFFFF))
      instr_count <= instr_count + 16'h0001;
  end

endmodule

// File: tb/tb_uc_secuenciada.sv
// tb/tb_uc_secuenciada.sv - directed self-checking bench for uc_secuenciada
module tb_uc_secuenciada;
  import uc_pkg::*;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic        zero;
  logic        run;
  logic        step;
  logic        s_inc;
  logic        s_inm;
  logic        we3;
  logic        wez;
  logic [2:0]  ALUOp;
  logic        pc_en;
  logic        halted;
  logic [15:0] instr_count;

  int total = 0;
  int bad   = 0;
  int n_exec;
  int exp_cnt;

  uc_secuenciada dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .zero        (zero),
    .run         (run),
    .step        (step),
    .s_inc       (s_inc),
    .s_inm       (s_inm),
    .we3         (we3),
    .wez         (wez),
    .ALUOp       (ALUOp),
    .pc_en       (pc_en),
    .halted      (halted),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset  = 1'b0;
    run    = 1'b1;
    step   = 1'b0;
    zero   = 1'b0;
    opcode = 6'b100000;
    #3;
    chk("rst_pc_en_async", 32'(pc_en), 0);
    chk("rst_we3_async", 32'(we3), 0);
    chk("rst_cnt_async", 32'(instr_count), 0);
    chk("rst_halted_async", 32'(halted), 0);
    tick();
    tick();
    chk("rst_pc_en_held", 32'(pc_en), 0);
    chk("rst_state_held", 32'(dut.state), 32'(S_IDLE));

    reset = 1'b1;
    #1;
    chk("rel_idle", 32'(dut.state), 32'(S_IDLE));
    chk("rel_pc_en0", 32'(pc_en), 0);
    tick();
    chk("rel_run", 32'(dut.state), 32'(S_RUN));
    chk("rel_pc_en1", 32'(pc_en), 1);
    chk("alu_we3", 32'(we3), 1);
    chk("alu_wez", 32'(wez), 1);
    chk("alu_s_inc", 32'(s_inc), 1);
    chk("cnt_first", 32'(instr_count), 0);
    opcode = 6'b110100;
    #1;
    chk("alu_op_101", 32'(ALUOp), 5);
    chk("alu_s_inm", 32'(s_inm), 0);
    tick();
    chk("cnt_1", 32'(instr_count), 1);

    opcode = 6'b000101;
    zero   = 1'b1;
    #1;
    chk("jz_taken_s_inc", 32'(s_inc), 0);
    chk("jz_we3", 32'(we3), 0);
    chk("jz_wez", 32'(wez), 0);
    chk("jz_pc_en", 32'(pc_en), 1);
    zero = 1'b0;
    #1;
    chk("jz_not_taken_s_inc", 32'(s_inc), 1);
    opcode = 6'b000110;
    zero   = 1'b1;
    #1;
    chk("jnz_not_taken_s_inc", 32'(s_inc), 1);
    opcode = 6'b000100;
    #1;
    chk("j_s_inc", 32'(s_inc), 0);
    opcode = 6'b000000;
    #1;
    chk("li_s_inm", 32'(s_inm), 1);
    chk("li_we3", 32'(we3), 1);
    chk("li_wez", 32'(wez), 0);
    chk("li_alu_op", 32'(ALUOp), 32'(ALU_PASS_B));
    opcode = 6'b010000;
    #1;
    chk("nop_we3", 32'(we3), 0);
    chk("nop_s_inc", 32'(s_inc), 1);
    tick();
    chk("cnt_2", 32'(instr_count), 2);

    // leaving RUN: the edge that samples run=0 still executes
    run = 1'b0;
    tick();
    chk("run_to_idle", 32'(dut.state), 32'(S_IDLE));
    chk("idle_pc_en", 32'(pc_en), 0);
    chk("cnt_3", 32'(instr_count), 3);

    opcode = 6'b000000;
    step   = 1'b1;
    n_exec = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (we3 && pc_en) n_exec++;
    end
    step = 1'b0;
    chk("step_one_exec", 32'(n_exec), 1);
    chk("step_cnt", 32'(instr_count), 4);
    chk("step_back_idle", 32'(dut.state), 32'(S_IDLE));
    tick();

    run  = 1'b1;
    step = 1'b1;
    tick();
    chk("prio_run", 32'(dut.state), 32'(S_RUN));
    run  = 1'b0;
    step = 1'b0;
    tick();
    chk("prio_idle", 32'(dut.state), 32'(S_IDLE));
    chk("prio_cnt", 32'(instr_count), 5);

    opcode  = 6'b100000;
    run     = 1'b1;
    tick();
    exp_cnt = 5;
    while (exp_cnt < 16'hFFFE) begin
      tick();
      exp_cnt++;
    end
    chk("sat_preload", 32'(instr_count), 32'hFFFE);
    tick();
    chk("sat_ffff", 32'(instr_count), 32'hFFFF);
    tick();
    tick();
    chk("sat_hold", 32'(instr_count), 32'hFFFF);

    reset = 1'b0;
    #1;
    chk("midrun_rst_cnt", 32'(instr_count), 0);
    chk("midrun_rst_we3", 32'(we3), 0);
    chk("midrun_rst_state", 32'(dut.state), 32'(S_IDLE));
    tick();
    reset = 1'b1;
    tick();
    tick();
    tick();
    chk("pre_halt_cnt", 32'(instr_count), 2);
    opcode = 6'b000111;
    #1;
    chk("halt_pc_en", 32'(pc_en), 0);
    chk("halt_we3", 32'(we3), 0);
    chk("halt_s_inc", 32'(s_inc), 1);
    chk("halt_not_yet", 32'(halted), 0);
    tick();
    chk("halted_set", 32'(halted), 1);
    chk("halted_state", 32'(dut.state), 32'(S_HALTED));
    opcode = 6'b100000;
    for (int i = 0; i < 4; i++) begin
      run  = (i % 2) == 0;
      step = (i % 2) != 0;
      tick();
      chk("halted_pc_en", 32'(pc_en), 0);
      chk("halted_cnt", 32'(instr_count), 2);
    end
    chk("halted_sticky", 32'(halted), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
